// File: rtl/mem_stage_ctrl_if.sv
// Purpose: bundles the EX/MEM input handshake, the MEM port and the WB bundle
//          of the memory-stage sequencer into one interface.
// Ports:   slave  - view used by mem_stage_ctrl (in_* and ReadData in, rest out)
//          master - view used by the surrounding pipeline / memory model
interface mem_stage_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_W  = 3
);
  // EX/MEM side
  logic              in_valid;
  logic              in_ready;
  logic              in_memread;
  logic              in_memwrite;
  logic              in_regwrite;
  logic [ADDR_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_W-1:0]  in_rd;
  logic              stall;

  // MEM side
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  // WB side
  logic              wb_valid;
  logic              wb_regwrite;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err_conflict;

  modport slave (
    input  in_valid, in_memread, in_memwrite, in_regwrite, in_alu_result,
           in_store_data, in_rd, ReadData,
    output in_ready, stall, MemRead, MemWrite, Address, WriteData,
           wb_valid, wb_regwrite, wb_rd, wb_data, err_conflict
  );

  modport master (
    output in_valid, in_memread, in_memwrite, in_regwrite, in_alu_result,
           in_store_data, in_rd, ReadData,
    input  in_ready, stall, MemRead, MemWrite, Address, WriteData,
           wb_valid, wb_regwrite, wb_rd, wb_data, err_conflict
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Purpose: memory-stage sequencer. ALU ops and stores finish in one cycle;
//          loads run a two-cycle MEM read (RD_ADDR, RD_DATA) while holding
//          off upstream, then present the captured ReadData to WB.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset
//          bus  - mem_stage_ctrl_if.slave (EX/MEM handshake, MEM port, WB bundle)
module mem_stage_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned REG_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_stage_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t state, stateNext;

  logic              accept;
  logic              inReady;

  // Load destination held across the two-cycle read
  logic [REG_W-1:0]  latchRd,  latchRdD;
  logic              latchRegWrite, latchRegWriteD;

  // Next values of the registered outputs
  logic              memReadD, memWriteD;
  logic [ADDR_W-1:0] addressD;
  logic [DATA_W-1:0] writeDataD;
  logic              wbValidD, wbRegWriteD;
  logic [REG_W-1:0]  wbRdD;
  logic [DATA_W-1:0] wbDataD;
  logic              errConflictD;

  assign accept = bus.in_valid && (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && bus.in_memread) stateNext = RD_ADDR;
      RD_ADDR: stateNext = RD_DATA;
      RD_DATA: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: combinational handshake plus next values of registered outputs
  always_comb begin
    inReady        = (state == IDLE);
    bus.in_ready   = inReady;
    bus.stall      = bus.in_valid & ~inReady;

    memReadD       = bus.MemRead;
    memWriteD      = 1'b0;
    addressD       = bus.Address;
    writeDataD     = bus.WriteData;
    wbValidD       = 1'b0;
    wbRegWriteD    = bus.wb_regwrite;
    wbRdD          = bus.wb_rd;
    wbDataD        = bus.wb_data;
    errConflictD   = bus.err_conflict;
    latchRdD       = latchRd;
    latchRegWriteD = latchRegWrite;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_memread) begin
            // Load wins over a simultaneous store; the write is suppressed
            memReadD       = 1'b1;
            addressD       = bus.in_alu_result;
            latchRdD       = bus.in_rd;
            latchRegWriteD = bus.in_regwrite;
            if (bus.in_memwrite) errConflictD = 1'b1;
          end else if (bus.in_memwrite) begin
            memWriteD   = 1'b1;
            addressD    = bus.in_alu_result;
            writeDataD  = bus.in_store_data;
            wbValidD    = 1'b1;
            wbRegWriteD = 1'b0;
          end else begin
            wbValidD    = 1'b1;
            wbDataD     = DATA_W'(bus.in_alu_result);
            wbRegWriteD = bus.in_regwrite;
            wbRdD       = bus.in_rd;
          end
        end
      end
      RD_ADDR: memReadD = 1'b1;
      RD_DATA: begin
        memReadD    = 1'b0;
        wbValidD    = 1'b1;
        wbDataD     = bus.ReadData;
        wbRegWriteD = latchRegWrite;
        wbRdD       = latchRd;
      end
      default: memReadD = 1'b0;
    endcase
  end

  // Registered outputs and load latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MemRead      <= 1'b0;
      bus.MemWrite     <= 1'b0;
      bus.Address      <= '0;
      bus.WriteData    <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_regwrite  <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.err_conflict <= 1'b0;
      latchRd          <= '0;
      latchRegWrite    <= 1'b0;
    end else begin
      bus.MemRead      <= memReadD;
      bus.MemWrite     <= memWriteD;
      bus.Address      <= addressD;
      bus.WriteData    <= writeDataD;
      bus.wb_valid     <= wbValidD;
      bus.wb_regwrite  <= wbRegWriteD;
      bus.wb_rd        <= wbRdD;
      bus.wb_data      <= wbDataD;
      bus.err_conflict <= errConflictD;
      latchRd          <= latchRdD;
      latchRegWrite    <= latchRegWriteD;
    end
  end

endmodule
